des_sbox_engine: RTL and testbench

//   Registered DES S-box substitution engine: evaluates all eight DES S-boxes (S1..S8) on a 48-bit

---
 rtl/des_sbox_engine_if.sv | 29 ++
 rtl/des_sbox_engine.sv | 149 ++++++++++++++
 tb/tb_des_sbox_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/des_sbox_engine_if.sv
// rtl/des_sbox_engine_if.sv - handshake bundle for the DES S-box engine
//
// Groups the input word handshake, abort, output word handshake and busy flag.
//   in_valid/in_ready/in_data[47:0]   : word to substitute (S1 in [47:42] .. S8 in [5:0])
//   abort                             : drops the word in flight
//   out_valid/out_ready/out_data[31:0]: substitution result (S1 in [31:28] .. S8 in [3:0])
//   busy                              : engine not idle
// master = word producer/consumer side, slave = engine side.

interface des_sbox_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, abort, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, abort, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/des_sbox_engine.sv
// rtl/des_sbox_engine.sv - registered DES S-box substitution engine, LANES boxes per cycle
//
// Evaluates S1..S8 on a captured 48-bit word, LANES boxes per clock over STEPS = 8/LANES
// cycles, then presents the 32-bit result until the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : des_sbox_engine_if.slave (in_*, abort, out_*, busy)
// Parameter LANES: 1, 2, 4 or 8.

module des_sbox_engine #(
    parameter int LANES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    des_sbox_engine_if.slave bus
);
    localparam int STEPS = 8 / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
            $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] step, step_nx;
    logic [47:0]   in_reg;
    logic [31:0]   res_reg, res_nx;
    logic          accept;
    int            box_idx;
    logic [5:0]    chunk;

    // One FIPS 46-3 table row per entry, column 0 in the top nibble.
    // The select is {box, c[5], c[0]} with box 0 = S1.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] c);
        logic [63:0] row_bits;
        logic [63:0] shifted;
        row_bits = '0;
        case ({box, c[5], c[0]})
            5'b000_00: row_bits = 64'hE4D12FB83A6C5907;
            5'b000_01: row_bits = 64'h0F74E2D1A6CB9538;
            5'b000_10: row_bits = 64'h41E8D62BFC973A50;
            5'b000_11: row_bits = 64'hFC8249175B3EA06D;
            5'b001_00: row_bits = 64'hF18E6B34972DC05A;
            5'b001_01: row_bits = 64'h3D47F28EC01A69B5;
            5'b001_10: row_bits = 64'h0E7BA4D158C6932F;
            5'b001_11: row_bits = 64'hD8A13F42B67C05E9;
            5'b010_00: row_bits = 64'hA09E63F51DC7B428;
            5'b010_01: row_bits = 64'hD709346A285ECBF1;
            5'b010_10: row_bits = 64'hD6498F30B12C5AE7;
            5'b010_11: row_bits = 64'h1AD069874FE3B52C;
            5'b011_00: row_bits = 64'h7DE3069A1285BC4F;
            5'b011_01: row_bits = 64'hD8B56F03472C1AE9;
            5'b011_10: row_bits = 64'hA690CB7DF13E5284;
            5'b011_11: row_bits = 64'h3F06A1D8945BC72E;
            5'b100_00: row_bits = 64'h2C417AB6853FD0E9;
            5'b100_01: row_bits = 64'hEB2C47D150FA3986;
            5'b100_10: row_bits = 64'h421BAD78F9C5630E;
            5'b100_11: row_bits = 64'hB8C71E2D6F09A453;
            5'b101_00: row_bits = 64'hC1AF92680D34E75B;
            5'b101_01: row_bits = 64'hAF427C9561DE0B38;
            5'b101_10: row_bits = 64'h9EF528C3704A1DB6;
            5'b101_11: row_bits = 64'h432C95FABE17608D;
            5'b110_00: row_bits = 64'h4B2EF08D3C975A61;
            5'b110_01: row_bits = 64'hD0B7491AE35C2F86;
            5'b110_10: row_bits = 64'h14BDC37EAF680592;
            5'b110_11: row_bits = 64'h6BD814A7950FE23C;
            5'b111_00: row_bits = 64'hD2846FB1A93E50C7;
            5'b111_01: row_bits = 64'h1FD8A374C56B0E92;
            5'b111_10: row_bits = 64'h7B419CE206ADF358;
            5'b111_11: row_bits = 64'h21E74A8DFC90356B;
            default:   row_bits = '0;
        endcase
        // Column c[4:1] selects nibble (15 - col) counted from the bottom.
        shifted = row_bits << {c[4:1], 2'b00};
        return shifted[63:60];
    endfunction

    // ABORT wins over IN_VALID, so nothing is captured on an aborted accept cycle.
    assign accept = (state == IDLE) && bus.in_valid && !bus.abort;

    always_comb begin
        state_nx = state;
        step_nx  = step;
        res_nx   = res_reg;
        box_idx  = 0;
        chunk    = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CALC;
                    step_nx  = '0;
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else begin
                    // Only this step's boxes are written; other nibbles hold.
                    for (int l = 0; l < LANES; l++) begin
                        box_idx = int'(step) * LANES + l;
                        chunk   = in_reg[6*(7-box_idx) +: 6];
                        res_nx[4*(7-box_idx) +: 4] = sbox_lookup(3'(box_idx), chunk);
                    end
                    if (int'(step) == STEPS - 1) begin
                        state_nx = DONE;
                    end else begin
                        step_nx = step + 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.abort || bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= '0;
            in_reg  <= '0;
            res_reg <= '0;
        end else begin
            state   <= state_nx;
            step    <= step_nx;
            res_reg <= res_nx;
            if (accept) begin
                in_reg <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = res_reg;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_des_sbox_engine.sv
// tb/tb_des_sbox_engine.sv - directed bench for des_sbox_engine at LANES 8, 1 and 2

module tb_des_sbox_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_sbox_engine_if b8 ();
    des_sbox_engine_if b1 ();
    des_sbox_engine_if b2 ();

    des_sbox_engine #(.LANES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    des_sbox_engine #(.LANES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    des_sbox_engine #(.LANES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int vecs = 0;
    int errs = 0;

    // FIPS 46-3 tables, row-major: entry = row*16 + col.
    int g [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    function automatic logic [31:0] gold_word(input logic [47:0] d);
        logic [31:0] w;
        logic [5:0]  c;
        int          idx;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            c   = d[6*(7-b) +: 6];
            idx = ((c[5] ? 2 : 0) + (c[0] ? 1 : 0)) * 16 + int'(c[4:1]);
            w[4*(7-b) +: 4] = 4'(g[b][idx]);
        end
        return w;
    endfunction

    // w: 0 = LANES 8, 1 = LANES 1, 2 = LANES 2
    task automatic drive(input int w, input logic v, input logic [47:0] d,
                         input logic ab, input logic ordy);
        case (w)
            0: begin b8.in_valid = v; b8.in_data = d; b8.abort = ab; b8.out_ready = ordy; end
            1: begin b1.in_valid = v; b1.in_data = d; b1.abort = ab; b1.out_ready = ordy; end
            default: begin b2.in_valid = v; b2.in_data = d; b2.abort = ab; b2.out_ready = ordy; end
        endcase
    endtask

    function automatic logic ir(input int w);
        return (w == 0) ? b8.in_ready : (w == 1) ? b1.in_ready : b2.in_ready;
    endfunction
    function automatic logic ov(input int w);
        return (w == 0) ? b8.out_valid : (w == 1) ? b1.out_valid : b2.out_valid;
    endfunction
    function automatic logic bsy(input int w);
        return (w == 0) ? b8.busy : (w == 1) ? b1.busy : b2.busy;
    endfunction
    function automatic logic [31:0] od(input int w);
        return (w == 0) ? b8.out_data : (w == 1) ? b1.out_data : b2.out_data;
    endfunction

    // Pushes one word through engine w from IDLE; lat = edges after accept until OUT_VALID,
    // calc = sampled cycles with busy and no OUT_VALID.
    task automatic send(input int w, input logic [47:0] d, output logic [31:0] r,
                        output int lat, output int calc);
        @(negedge clk);
        drive(w, 1'b1, d, 1'b0, 1'b0);
        @(negedge clk);
        drive(w, 1'b0, '0, 1'b0, 1'b0);
        lat  = 0;
        calc = 0;
        while (!ov(w) && lat < 40) begin
            if (bsy(w)) calc++;
            @(negedge clk);
            lat++;
        end
        r = od(w);
        drive(w, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        drive(w, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            vecs++; if (ir(w) !== 1'b1) begin errs++; $display("FAIL reset_in_ready[%0d] got %b want 1", w, ir(w)); end
            vecs++; if (ov(w) !== 1'b0) begin errs++; $display("FAIL reset_out_valid[%0d] got %b want 0", w, ov(w)); end
            vecs++; if (od(w) !== 32'h0) begin errs++; $display("FAIL reset_out_data[%0d] got %h want 0", w, od(w)); end
            vecs++; if (bsy(w) !== 1'b0) begin errs++; $display("FAIL reset_busy[%0d] got %b want 0", w, bsy(w)); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lanes8_known();
        logic [31:0] r;
        int lat, calc;
        send(0, 48'h0, r, lat, calc);
        vecs++; if (r !== 32'hEFA72C4D) begin errs++; $display("FAIL l8_zero_data got %h want efa72c4d", r); end
        vecs++; if (lat != 1) begin errs++; $display("FAIL l8_zero_latency got %0d want 1", lat); end
        send(0, 48'hFFFFFFFFFFFF, r, lat, calc);
        vecs++; if (r !== 32'hD9CE3DCB) begin errs++; $display("FAIL l8_ones_data got %h want d9ce3dcb", r); end
        vecs++; if (lat != 1) begin errs++; $display("FAIL l8_ones_latency got %0d want 1", lat); end
    endtask

    task automatic test_lanes1();
        logic [31:0] r;
        int lat, calc;
        send(1, 48'h0, r, lat, calc);
        vecs++; if (r !== 32'hEFA72C4D) begin errs++; $display("FAIL l1_data got %h want efa72c4d", r); end
        vecs++; if (lat != 8) begin errs++; $display("FAIL l1_latency got %0d want 8", lat); end
        vecs++; if (calc != 8) begin errs++; $display("FAIL l1_calc_cycles got %0d want 8", calc); end
    endtask

    task automatic test_hold();
        logic [47:0] d;
        logic [31:0] exp;
        d   = 48'h0123456789AB;
        exp = gold_word(d);
        @(negedge clk); drive(0, 1'b1, d, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 48'hFFFFFFFFFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            vecs++; if (ov(0) !== 1'b1) begin errs++; $display("FAIL hold_out_valid[%0d] got %b want 1", i, ov(0)); end
            vecs++; if (od(0) !== exp) begin errs++; $display("FAIL hold_out_data[%0d] got %h want %h", i, od(0), exp); end
            vecs++; if (ir(0) !== 1'b0) begin errs++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, ir(0)); end
            @(negedge clk);
        end
        drive(0, 1'b1, 48'hFFFFFFFFFFFF, 1'b0, 1'b1);
        @(negedge clk);
        vecs++; if (bsy(0) !== 1'b0) begin errs++; $display("FAIL handoff_busy got %b want 0", bsy(0)); end
        vecs++; if (ir(0) !== 1'b1) begin errs++; $display("FAIL handoff_in_ready got %b want 1", ir(0)); end
        vecs++; if (ov(0) !== 1'b0) begin errs++; $display("FAIL handoff_out_valid got %b want 0", ov(0)); end
        drive(0, 1'b1, 48'hFFFFFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        vecs++; if (bsy(0) !== 1'b1) begin errs++; $display("FAIL held_word_accept got %b want 1", bsy(0)); end
        @(negedge clk);
        vecs++; if (od(0) !== 32'hD9CE3DCB) begin errs++; $display("FAIL held_word_data got %h want d9ce3dcb", od(0)); end
        drive(0, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk); drive(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        vecs++; if (od(0) !== 32'hD9CE3DCB) begin errs++; $display("FAIL retain_out_data got %h want d9ce3dcb", od(0)); end
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        @(negedge clk);
        drive(0, 1'b1, 48'h0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (ov(0)) seen++;
        end
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        vecs++; if (seen != 3) begin errs++; $display("FAIL b2b_outputs got %0d want 3", seen); end
        @(negedge clk);
        vecs++; if (bsy(0) !== 1'b0) begin errs++; $display("FAIL b2b_idle got %b want 0", bsy(0)); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        int lat, calc, seen;
        @(negedge clk); drive(2, 1'b1, 48'h0, 1'b0, 1'b0);
        @(negedge clk); drive(2, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(2, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        drive(2, 1'b0, '0, 1'b0, 1'b0);
        vecs++; if (bsy(2) !== 1'b0) begin errs++; $display("FAIL abort_calc_busy got %b want 0", bsy(2)); end
        vecs++; if (ir(2) !== 1'b1) begin errs++; $display("FAIL abort_calc_in_ready got %b want 1", ir(2)); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (ov(2)) seen++;
            @(negedge clk);
        end
        vecs++; if (seen != 0) begin errs++; $display("FAIL abort_calc_no_output got %0d want 0", seen); end
        send(2, 48'hFFFFFFFFFFFF, r, lat, calc);
        vecs++; if (r !== 32'hD9CE3DCB) begin errs++; $display("FAIL l2_after_abort_data got %h want d9ce3dcb", r); end
        vecs++; if (lat != 4) begin errs++; $display("FAIL l2_latency got %0d want 4", lat); end
        // ABORT with IN_VALID in IDLE
        @(negedge clk); drive(2, 1'b1, 48'h123456789ABC, 1'b1, 1'b0);
        @(negedge clk); drive(2, 1'b0, '0, 1'b0, 1'b0);
        vecs++; if (bsy(2) !== 1'b0) begin errs++; $display("FAIL abort_idle_busy got %b want 0", bsy(2)); end
        // ABORT beats OUT_READY in DONE; result register is not touched
        @(negedge clk); drive(0, 1'b1, 48'h0, 1'b0, 1'b0);
        @(negedge clk); drive(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        vecs++; if (ov(0) !== 1'b1) begin errs++; $display("FAIL abort_done_pre_valid got %b want 1", ov(0)); end
        drive(0, 1'b0, '0, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0, 1'b0);
        vecs++; if (ov(0) !== 1'b0) begin errs++; $display("FAIL abort_done_valid got %b want 0", ov(0)); end
        vecs++; if (bsy(0) !== 1'b0) begin errs++; $display("FAIL abort_done_busy got %b want 0", bsy(0)); end
        vecs++; if (od(0) !== 32'hEFA72C4D) begin errs++; $display("FAIL abort_done_data got %h want efa72c4d", od(0)); end
    endtask

    task automatic test_sweep();
        logic [47:0] d;
        logic [31:0] r, exp;
        int lat, calc;
        for (int b = 0; b < 8; b++) begin
            for (int v = 0; v < 64; v++) begin
                d   = 48'(v) << (6 * (7 - b));
                exp = gold_word(d);
                send(0, d, r, lat, calc);
                vecs++;
                if (r !== exp) begin
                    errs++;
                    $display("FAIL sweep_s%0d_%0d got %h want %h", b + 1, v, r, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive(1, 1'b1, 48'hFFFFFFFFFFFF, 1'b0, 1'b0);
        @(negedge clk); drive(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int w = 0; w < 3; w++) begin
            vecs++; if (ir(w) !== 1'b1) begin errs++; $display("FAIL midrst_in_ready[%0d] got %b want 1", w, ir(w)); end
            vecs++; if (ov(w) !== 1'b0) begin errs++; $display("FAIL midrst_out_valid[%0d] got %b want 0", w, ov(w)); end
            vecs++; if (od(w) !== 32'h0) begin errs++; $display("FAIL midrst_out_data[%0d] got %h want 0", w, od(w)); end
            vecs++; if (bsy(w) !== 1'b0) begin errs++; $display("FAIL midrst_busy[%0d] got %b want 0", w, bsy(w)); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int w = 0; w < 3; w++) drive(w, 1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_lanes8_known();
        test_lanes1();
        test_hold();
        test_back_to_back();
        test_abort();
        test_sweep();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
